bp_io_order_splitter: RTL and testbench

- Routes I/O commands from the BlackParrot unicore I/O-out port to one of two targets: the host I/O link or the on-chip ethernet controller.
- Target is chosen by address decode.
- Records the target of every accepted command in an order FIFO. Responses return to the core strictly in command order, and only the expected target is drained.
- Replaces ad-hoc priority muxing of host and ethernet responses in the tethered top level.

---
 rtl/bp_io_order_splitter.sv | 131 +++++++++++++
 tb/tb_bp_io_order_splitter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_io_order_splitter.sv
// Routes core I/O commands to host or ethernet and returns responses in order.
// Ports: cmd_* in from the core, host_cmd_*/eth_cmd_* out, host_resp_*/eth_resp_* in,
//        resp_* to the core, outstanding_o = commands awaiting a response,
//        err_o = sticky protocol error.
module bp_io_order_splitter #(
    parameter int unsigned                   msg_width_p      = 256,
    parameter int unsigned                   addr_width_p     = 40,
    parameter int unsigned                   dev_lsb_p        = 20,
    parameter int unsigned                   dev_width_p      = 4,
    parameter logic [dev_width_p-1:0]        eth_dev_id_p     = 4'hA,
    parameter logic [addr_width_p-1:0]       dram_base_addr_p = 40'h80_0000_0000,
    parameter int unsigned                   els_p            = 4,
    localparam int unsigned                  ptr_w_lp         = $clog2(els_p),
    localparam int unsigned                  cnt_w_lp         = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  logic [msg_width_p-1:0]  cmd_i,
    input  logic [addr_width_p-1:0] cmd_addr_i,
    input  logic                    cmd_v_i,
    output logic                    cmd_ready_and_o,

    output logic [msg_width_p-1:0]  host_cmd_o,
    output logic                    host_cmd_v_o,
    input  logic                    host_cmd_ready_and_i,

    output logic [msg_width_p-1:0]  eth_cmd_o,
    output logic                    eth_cmd_v_o,
    input  logic                    eth_cmd_ready_and_i,

    input  logic [msg_width_p-1:0]  host_resp_i,
    input  logic                    host_resp_v_i,
    output logic                    host_resp_yumi_o,

    input  logic [msg_width_p-1:0]  eth_resp_i,
    input  logic                    eth_resp_v_i,
    output logic                    eth_resp_yumi_o,

    output logic [msg_width_p-1:0]  resp_o,
    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,

    output logic [cnt_w_lp-1:0]     outstanding_o,
    output logic                    err_o
);

    // Order FIFO state: one bit per outstanding command, 1 = ethernet
    logic [els_p-1:0]    order_q, order_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                err_q, err_d;

    logic is_eth;
    logic full;
    logic empty;
    logic head;
    logic push;
    logic pop;

    assign full  = (count_q == cnt_w_lp'(els_p));
    assign empty = (count_q == '0);

    // Anything at or above DRAM base is memory-mapped host space
    assign is_eth = (cmd_addr_i < dram_base_addr_p)
                  & (cmd_addr_i[dev_lsb_p+:dev_width_p] == eth_dev_id_p);

    // Command path: pure wires, ready follows only the selected target
    assign host_cmd_o      = cmd_i;
    assign eth_cmd_o       = cmd_i;
    assign host_cmd_v_o    = cmd_v_i & ~is_eth & ~full;
    assign eth_cmd_v_o     = cmd_v_i &  is_eth & ~full;
    assign cmd_ready_and_o = ~full
                           & (is_eth ? eth_cmd_ready_and_i : host_cmd_ready_and_i);

    // Response path: only the target recorded at the head may drain
    assign head             = ~empty & order_q[rptr_q];
    assign resp_o           = head ? eth_resp_i : host_resp_i;
    assign resp_v_o         = ~empty & (head ? eth_resp_v_i : host_resp_v_i);
    assign host_resp_yumi_o = resp_yumi_i & resp_v_o & ~head;
    assign eth_resp_yumi_o  = resp_yumi_i & resp_v_o &  head;

    assign push = cmd_v_i & cmd_ready_and_o;
    assign pop  = resp_yumi_i & resp_v_o;

    always_comb begin
        order_d = order_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        err_d   = err_q;

        if (push) begin
            order_d[wptr_q] = is_eth;
            wptr_d          = wptr_q + ptr_w_lp'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + ptr_w_lp'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase

        if ((empty & (host_resp_v_i | eth_resp_v_i)) | (resp_yumi_i & ~resp_v_o)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            order_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            order_q <= order_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_bp_io_order_splitter.sv
// Directed-vector bench for bp_io_order_splitter.
// Drives inputs 1 time unit after the rising edge and checks after settling.
module tb_bp_io_order_splitter;

    localparam int MW = 256;
    localparam int AW = 40;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [MW-1:0] cmd;
    logic [AW-1:0] cmd_addr;
    logic          cmd_v;
    logic          cmd_ready;
    logic [MW-1:0] host_cmd;
    logic          host_cmd_v;
    logic          host_cmd_ready;
    logic [MW-1:0] eth_cmd;
    logic          eth_cmd_v;
    logic          eth_cmd_ready;
    logic [MW-1:0] host_resp;
    logic          host_resp_v;
    logic          host_resp_yumi;
    logic [MW-1:0] eth_resp;
    logic          eth_resp_v;
    logic          eth_resp_yumi;
    logic [MW-1:0] resp;
    logic          resp_v;
    logic          resp_yumi;
    logic [2:0]    outstanding;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    bp_io_order_splitter dut (
        .clk_i                (clk),
        .reset_n_i            (reset_n),
        .cmd_i                (cmd),
        .cmd_addr_i           (cmd_addr),
        .cmd_v_i              (cmd_v),
        .cmd_ready_and_o      (cmd_ready),
        .host_cmd_o           (host_cmd),
        .host_cmd_v_o         (host_cmd_v),
        .host_cmd_ready_and_i (host_cmd_ready),
        .eth_cmd_o            (eth_cmd),
        .eth_cmd_v_o          (eth_cmd_v),
        .eth_cmd_ready_and_i  (eth_cmd_ready),
        .host_resp_i          (host_resp),
        .host_resp_v_i        (host_resp_v),
        .host_resp_yumi_o     (host_resp_yumi),
        .eth_resp_i           (eth_resp),
        .eth_resp_v_i         (eth_resp_v),
        .eth_resp_yumi_o      (eth_resp_yumi),
        .resp_o               (resp),
        .resp_v_o             (resp_v),
        .resp_yumi_i          (resp_yumi),
        .outstanding_o        (outstanding),
        .err_o                (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [MW-1:0] got,
                       input logic [MW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n        = 1'b0;
        cmd            = '0;
        cmd_addr       = '0;
        cmd_v          = 1'b0;
        host_cmd_ready = 1'b1;
        eth_cmd_ready  = 1'b0;
        host_resp      = '0;
        host_resp_v    = 1'b0;
        eth_resp       = '0;
        eth_resp_v     = 1'b0;
        resp_yumi      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;

        // Reset state
        chk("rst_outstanding", MW'(outstanding), 0);
        chk("rst_err", MW'(err), 0);
        chk("rst_resp_v", MW'(resp_v), 0);
        chk("rst_host_yumi", MW'(host_resp_yumi), 0);
        chk("rst_eth_yumi", MW'(eth_resp_yumi), 0);
        chk("rst_ready_host", MW'(cmd_ready), 1);

        // Host command and response
        cmd      = MW'(256'h1234_5678);
        cmd_addr = 40'h00_0020_0000;
        cmd_v    = 1'b1;
        #1;
        chk("h_cmd_v", MW'(host_cmd_v), 1);
        chk("h_eth_v", MW'(eth_cmd_v), 0);
        chk("h_ready", MW'(cmd_ready), 1);
        chk("h_data", host_cmd, MW'(256'h1234_5678));
        tick();
        cmd_v = 1'b0;
        #1;
        chk("h_out1", MW'(outstanding), 1);
        host_resp   = MW'(256'hAAAA_0001);
        host_resp_v = 1'b1;
        resp_yumi   = 1'b1;
        #1;
        chk("h_resp_v", MW'(resp_v), 1);
        chk("h_resp", resp, MW'(256'hAAAA_0001));
        chk("h_yumi", MW'(host_resp_yumi), 1);
        chk("h_eyumi", MW'(eth_resp_yumi), 0);
        tick();
        host_resp_v = 1'b0;
        resp_yumi   = 1'b0;
        #1;
        chk("h_out0", MW'(outstanding), 0);

        // Ethernet command held off by eth ready
        cmd_addr = 40'h00_00A0_0010;
        cmd_v    = 1'b1;
        #1;
        chk("e_ready0", MW'(cmd_ready), 0);
        chk("e_cmd_v", MW'(eth_cmd_v), 1);
        chk("e_host_v", MW'(host_cmd_v), 0);
        tick();
        chk("e_nopush", MW'(outstanding), 0);
        eth_cmd_ready = 1'b1;
        #1;
        chk("e_ready1", MW'(cmd_ready), 1);
        tick();
        cmd_v = 1'b0;
        #1;
        chk("e_out1", MW'(outstanding), 1);

        // Host command behind the eth one; host response arrives first
        cmd_addr = 40'h00_0020_0000;
        cmd_v    = 1'b1;
        tick();
        cmd_v = 1'b0;
        #1;
        chk("o_out2", MW'(outstanding), 2);
        host_resp   = MW'(256'hBBBB_0002);
        host_resp_v = 1'b1;
        #1;
        chk("o_hold_v", MW'(resp_v), 0);
        tick();
        chk("o_hold_out", MW'(outstanding), 2);
        chk("o_hold_err", MW'(err), 0);
        eth_resp   = MW'(256'hEEEE_0003);
        eth_resp_v = 1'b1;
        resp_yumi  = 1'b1;
        #1;
        chk("o_eth_v", MW'(resp_v), 1);
        chk("o_eth_data", resp, MW'(256'hEEEE_0003));
        chk("o_eth_yumi", MW'(eth_resp_yumi), 1);
        chk("o_host_held", MW'(host_resp_yumi), 0);
        tick();
        eth_resp_v = 1'b0;
        #1;
        chk("o_host_data", resp, MW'(256'hBBBB_0002));
        chk("o_host_yumi", MW'(host_resp_yumi), 1);
        tick();
        host_resp_v = 1'b0;
        resp_yumi   = 1'b0;
        #1;
        chk("o_out0", MW'(outstanding), 0);
        chk("o_err", MW'(err), 0);

        // Fill the order FIFO
        cmd_v = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("f_out4", MW'(outstanding), 4);
        chk("f_ready", MW'(cmd_ready), 0);
        chk("f_host_v", MW'(host_cmd_v), 0);
        host_resp_v = 1'b1;
        resp_yumi   = 1'b1;
        #1;
        chk("f_pop_ready", MW'(cmd_ready), 0);
        tick();
        host_resp_v = 1'b0;
        resp_yumi   = 1'b0;
        #1;
        chk("f_out3", MW'(outstanding), 3);
        chk("f_ready1", MW'(cmd_ready), 1);
        tick();
        cmd_v = 1'b0;
        #1;
        chk("f_out4b", MW'(outstanding), 4);
        host_resp_v = 1'b1;
        resp_yumi   = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        host_resp_v = 1'b0;
        resp_yumi   = 1'b0;
        #1;
        chk("f_drain", MW'(outstanding), 0);
        chk("f_err", MW'(err), 0);

        // DRAM-base boundary of the decode
        cmd_addr = 40'h80_00A0_0000;
        #1;
        chk("d_hi_host", MW'(host_cmd_v), 0);
        cmd_v = 1'b1;
        #1;
        chk("d_hi_host_v", MW'(host_cmd_v), 1);
        chk("d_hi_eth_v", MW'(eth_cmd_v), 0);
        cmd_addr = 40'h7F_FFA0_0000;
        #1;
        chk("d_lo_eth_v", MW'(eth_cmd_v), 1);
        chk("d_lo_host_v", MW'(host_cmd_v), 0);
        cmd_v = 1'b0;

        // Unexpected response while empty
        eth_resp_v = 1'b1;
        #1;
        chk("x_eyumi", MW'(eth_resp_yumi), 0);
        chk("x_resp_v", MW'(resp_v), 0);
        tick();
        eth_resp_v = 1'b0;
        #1;
        chk("x_err", MW'(err), 1);
        tick();
        chk("x_err_sticky", MW'(err), 1);

        // Reset mid-operation
        cmd_addr = 40'h00_0020_0000;
        cmd_v    = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        cmd_v = 1'b0;
        #1;
        chk("r_out3", MW'(outstanding), 3);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        chk("r_err", MW'(err), 0);
        chk("r_out", MW'(outstanding), 0);
        chk("r_resp_v", MW'(resp_v), 0);

        // Yumi without a valid response
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
        #1;
        chk("y_err", MW'(err), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
